sequenciador_oposto: RTL and testbench

//   Controller that sequences the additive-opposite datapath over a block of
//   8-bit unsigned operands held in coprocessor memory. On start it streams
//   len operands from source memory and writes each 9-bit two's-complement

---
 rtl/sequenciador_oposto_if.sv | 29 ++
 rtl/sequenciador_oposto.sv | 111 +++++++++++
 tb/tb_sequenciador_oposto.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sequenciador_oposto_if.sv
// Bus between the coprocessor decoder/RAMs and the additive-opposite sequencer.
// Signal suffixes are from the sequencer's point of view.
interface sequenciador_oposto_if #(
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 6
);
  logic              start_i;
  logic [ADDR_W-1:0] src_base_i;
  logic [ADDR_W-1:0] dst_base_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [7:0]        rd_data_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [8:0]        wr_data_o;

  modport master (
    output start_i, src_base_i, dst_base_i, len_i, rd_data_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  start_i, src_base_i, dst_base_i, len_i, rd_data_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/sequenciador_oposto.sv
// Streams len operands from source RAM and writes their 9-bit opposites to destination RAM.
// Optional OPOSTO_ABORT_EN adds an abort_i port that cuts a running block short.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start_i; block parameters latched on start
// S_RUN    | one source read per cycle, writes trail by one cycle
// S_DRAIN  | no read; final write of the block
// S_DONE   | one-cycle done pulse, then back to idle
module sequenciador_oposto #(
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 6
) (
  input logic clk_i,
  input logic reset_i,
`ifdef OPOSTO_ABORT_EN
  input logic abort_i,
`endif
  sequenciador_oposto_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_vld_q, wr_vld_d;

  logic abort_w;
  logic rd_fire;
  logic wr_fire;

`ifdef OPOSTO_ABORT_EN
  assign abort_w = abort_i && ((state_q == S_RUN) || (state_q == S_DRAIN));
`else
  assign abort_w = 1'b0;
`endif

  assign rd_fire = (state_q == S_RUN) && !abort_w;
  assign wr_fire = wr_vld_q && !abort_w;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    wr_vld_d  = rd_fire;
    wr_addr_d = rd_fire ? dst_q + idx_q : '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          src_d   = bus.src_base_i;
          dst_d   = bus.dst_base_i;
          rem_d   = bus.len_i;
          idx_d   = '0;
          state_d = (bus.len_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort_w) begin
          state_d = S_DONE;
        end else begin
          // rem_q is the remaining-read down-counter; terminal count is 1
          idx_d = idx_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      wr_addr_q <= '0;
      wr_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      wr_addr_q <= wr_addr_d;
      wr_vld_q  <= wr_vld_d;
    end
  end

  assign bus.busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done_o    = (state_q == S_DONE);
  assign bus.rd_en_o   = rd_fire;
  assign bus.rd_addr_o = rd_fire ? src_q + idx_q : '0;
  assign bus.wr_en_o   = wr_fire;
  assign bus.wr_addr_o = wr_fire ? wr_addr_q : '0;
  // Write data comes straight from the RAM output, one cycle after its read
  assign bus.wr_data_o = wr_fire ? 9'd0 - {1'b0, bus.rd_data_i} : 9'd0;

endmodule

// File: tb/tb_sequenciador_oposto.sv
// Randomized bench for sequenciador_oposto against a cycle-timing reference model.
// Build with OPOSTO_ABORT_EN defined to exercise the abort port.
module tb_sequenciador_oposto;
  localparam int ADDR_W = 5;
  localparam int LEN_W  = 6;
  localparam int DEPTH  = 32;
  localparam int NO_AB  = 1 << 30;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
`ifdef OPOSTO_ABORT_EN
  logic abort_i = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  sequenciador_oposto_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  sequenciador_oposto #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
`ifdef OPOSTO_ABORT_EN
    .abort_i (abort_i),
`endif
    .bus     (bus.slave)
  );

  logic [7:0] src_mem [DEPTH];

  always @(posedge clk_i)
    if (bus.rd_en_o) bus.rd_data_i <= src_mem[bus.rd_addr_o];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int c);
    chk($sformatf("busy@%0d", c), 32'(bus.busy_o), 0);
    chk($sformatf("done@%0d", c), 32'(bus.done_o), 0);
    chk($sformatf("rd_en@%0d", c), 32'(bus.rd_en_o), 0);
    chk($sformatf("rd_addr@%0d", c), 32'(bus.rd_addr_o), 0);
    chk($sformatf("wr_en@%0d", c), 32'(bus.wr_en_o), 0);
    chk($sformatf("wr_addr@%0d", c), 32'(bus.wr_addr_o), 0);
    chk($sformatf("wr_data@%0d", c), 32'(bus.wr_data_o), 0);
  endtask

  // Expected outputs in cycle c of a block started at cycle 0; lim is the abort cycle
  task automatic chk_cycle(input int c, input int src, input int dst, input int len,
                           input int lim, input int end_c);
    bit rd, wr;
    int ra, wa, wd;
    rd = (c >= 1) && (c <= len) && (c < lim);
    wr = (c >= 2) && (c <= len + 1) && (c < lim);
    ra = rd ? (src + c - 1) % DEPTH : 0;
    wa = wr ? (dst + c - 2) % DEPTH : 0;
    wd = wr ? (512 - int'(src_mem[(src + c - 2) % DEPTH])) % 512 : 0;
    chk($sformatf("busy@%0d", c), 32'(bus.busy_o), 32'(len != 0 && c < end_c));
    chk($sformatf("done@%0d", c), 32'(bus.done_o), 32'(c == end_c));
    chk($sformatf("rd_en@%0d", c), 32'(bus.rd_en_o), 32'(rd));
    chk($sformatf("rd_addr@%0d", c), 32'(bus.rd_addr_o), 32'(ra));
    chk($sformatf("wr_en@%0d", c), 32'(bus.wr_en_o), 32'(wr));
    chk($sformatf("wr_addr@%0d", c), 32'(bus.wr_addr_o), 32'(wa));
    chk($sformatf("wr_data@%0d", c), 32'(bus.wr_data_o), 32'(wd));
  endtask

  task automatic run_op(input int src, input int dst, input int len, input int ab, input bit junk);
    int end_c, lim;
    lim   = (ab > 0) ? ab : NO_AB;
    end_c = (ab > 0) ? ab + 1 : ((len == 0) ? 1 : len + 2);
    @(posedge clk_i); #1;
    bus.start_i    = 1'b1;
    bus.src_base_i = ADDR_W'(src);
    bus.dst_base_i = ADDR_W'(dst);
    bus.len_i      = LEN_W'(len);
    @(negedge clk_i);
    chk("busy@0", 32'(bus.busy_o), 0);
    for (int c = 1; c <= end_c + 1; c++) begin
      @(posedge clk_i); #1;
      bus.start_i = junk && (c == 2 || c == end_c) && (c <= end_c);
      if (bus.start_i) begin
        bus.src_base_i = ADDR_W'($urandom);
        bus.dst_base_i = ADDR_W'($urandom);
        bus.len_i      = LEN_W'($urandom_range(1, 63));
      end
`ifdef OPOSTO_ABORT_EN
      abort_i = (c == ab) || (junk && c == end_c);
`endif
      @(negedge clk_i);
      chk_cycle(c, src, dst, len, lim, end_c);
    end
    bus.start_i = 1'b0;
`ifdef OPOSTO_ABORT_EN
    abort_i = 1'b0;
`endif
  endtask

  initial begin
    int len, ab;
    bit junk;
    for (int i = 0; i < DEPTH; i++) src_mem[i] = 8'($urandom);
    bus.start_i    = 1'b0;
    bus.src_base_i = '0;
    bus.dst_base_i = '0;
    bus.len_i      = '0;

    reset_i = 1'b1;
    @(negedge clk_i);
    chk_idle(-2);
    @(negedge clk_i);
    chk_idle(-1);
    @(posedge clk_i); #1;
    reset_i = 1'b0;

    src_mem[0] = 8'd0;   src_mem[1] = 8'd1;   src_mem[2] = 8'd10;
    src_mem[3] = 8'd127; src_mem[4] = 8'd128; src_mem[5] = 8'd255;
    run_op(0, 8, 6, 0, 1'b0);
    run_op(3, 4, 0, 0, 1'b1);
    run_op(30, 31, 4, 0, 1'b0);

    // Reset in cycle 3 of a len=10 block, with a stray start in cycle 2
    @(posedge clk_i); #1;
    bus.start_i = 1'b1; bus.src_base_i = 5'd7; bus.dst_base_i = 5'd12; bus.len_i = 6'd10;
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk_i); #1;
      bus.start_i = (c == 2);
      if (bus.start_i) begin bus.src_base_i = 5'd20; bus.len_i = 6'd3; end
      @(negedge clk_i);
      chk_cycle(c, 7, 12, 10, NO_AB, 12);
    end
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    for (int c = 4; c < 20; c++) begin
      @(negedge clk_i);
      chk_idle(c);
    end

`ifdef OPOSTO_ABORT_EN
    run_op(0, 0, 8, 4, 1'b0);
`else
    run_op(0, 0, 8, 0, 1'b0);
`endif
    run_op(9, 9, 63, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < DEPTH; i++) src_mem[i] = 8'($urandom);
      len  = $urandom_range(0, 12);
      junk = 1'($urandom);
      ab   = 0;
`ifdef OPOSTO_ABORT_EN
      if (len > 0 && $urandom_range(0, 1) == 1) ab = $urandom_range(1, len + 1);
`endif
      run_op($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), len, ab, junk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
